// File: rtl/gf16_fac_pkg.sv
// Shared types and field positions for the 9-bit shared-factor GF(2^4) operand format.
// Each 3-bit group is {xor of element bits, 2-bit GF(2^2) element}.
package gf16_fac_pkg;
  localparam int FAC_W       = 9;
  localparam int FAC_SUM_MSB = 8;
  localparam int FAC_HI_MSB  = 5;
  localparam int FAC_LO_MSB  = 2;

  typedef enum logic [2:0] {IDLE, MUL_LO, MUL_HI, MUL_SUM, DONE} state_e;

  // A group is inconsistent when its sum bit disagrees with its element bits.
  function automatic logic fac_bad(input logic [FAC_W-1:0] f);
    return (^f[FAC_SUM_MSB -: 3]) | (^f[FAC_HI_MSB -: 3]) | (^f[FAC_LO_MSB -: 3]);
  endfunction
endpackage

// File: rtl/gf4_mul_fac.sv
// Combinational GF(2^2) normal-basis multiplier that reuses the supplied sum bits
// instead of recomputing them, so the shared factor is consumed as delivered.
module gf4_mul_fac (
  input  logic [1:0] x_i,
  input  logic       xs_i,
  input  logic [1:0] y_i,
  input  logic       ys_i,
  output logic [1:0] z_o
);
  logic e;

  assign e   = xs_i & ys_i;
  assign z_o = {(x_i[1] & y_i[1]) ^ e, (x_i[0] & y_i[0]) ^ e};
endmodule

// File: rtl/gf16_fac_mul_seq.sv
// Sequential GF(2^4) normal-basis multiplier on factored operands: one GF(2^2)
// multiplier is reused for the lo, hi and sum groups over three cycles.
module gf16_fac_mul_seq
  import gf16_fac_pkg::*;
#(
  parameter bit CHECK_FAC = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] fa,
  input  logic [8:0] fb,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_p,
  output logic       out_err
);
  state_e           state_q, state_d;
  logic [FAC_W-1:0] fa_q, fa_d, fb_q, fb_d;
  logic [1:0]       plo_q, plo_d, phi_q, phi_d;
  logic [3:0]       p_q, p_d;
  logic             err_q, err_d;
  logic [2:0]       ga, gb;
  logic [1:0]       m_z, ms_n;

  // Operand group steering for the shared multiplier.
  always_comb begin
    ga = fa_q[FAC_LO_MSB -: 3];
    gb = fb_q[FAC_LO_MSB -: 3];
    case (state_q)
      MUL_HI: begin
        ga = fa_q[FAC_HI_MSB -: 3];
        gb = fb_q[FAC_HI_MSB -: 3];
      end
      MUL_SUM: begin
        ga = fa_q[FAC_SUM_MSB -: 3];
        gb = fb_q[FAC_SUM_MSB -: 3];
      end
      default: ;
    endcase
  end

  gf4_mul_fac u_mul (
    .x_i  (ga[1:0]),
    .xs_i (ga[2]),
    .y_i  (gb[1:0]),
    .ys_i (gb[2]),
    .z_o  (m_z)
  );

  // Scale by N: {a,b} -> {b, a^b}.
  assign ms_n = {m_z[0], m_z[1] ^ m_z[0]};

  always_comb begin
    state_d   = state_q;
    fa_d      = fa_q;
    fb_d      = fb_q;
    plo_d     = plo_q;
    phi_d     = phi_q;
    p_d       = p_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fa_d    = fa;
          fb_d    = fb;
          state_d = MUL_LO;
        end
      end
      MUL_LO: begin
        plo_d   = m_z;
        state_d = MUL_HI;
      end
      MUL_HI: begin
        phi_d   = m_z;
        state_d = MUL_SUM;
      end
      MUL_SUM: begin
        p_d     = {phi_q ^ ms_n, plo_q ^ ms_n};
        err_d   = CHECK_FAC & (fac_bad(fa_q) | fac_bad(fb_q));
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // Scrub operand shares and partials once the product has left.
          fa_d    = '0;
          fb_d    = '0;
          plo_d   = '0;
          phi_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fa_q    <= '0;
      fb_q    <= '0;
      plo_q   <= '0;
      phi_q   <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      plo_q   <= plo_d;
      phi_q   <= phi_d;
      p_q     <= p_d;
      err_q   <= err_d;
    end
  end

  assign out_p   = p_q;
  assign out_err = err_q;
endmodule

// File: tb/tb_gf16_fac_mul_seq.sv
// Bench for gf16_fac_mul_seq: directed scenarios plus all 256 operand pairs
// against a log-table GF(2^2) tower model of GF(2^4) multiplication.
module tb_gf16_fac_mul_seq;
  logic       clk, rst, in_valid, out_ready;
  logic [8:0] fa, fb;
  logic       in_ready, out_valid, out_err;
  logic [3:0] out_p;
  logic       in_ready_nc, out_valid_nc, out_err_nc;
  logic [3:0] out_p_nc;
  int errors, checks;

  gf16_fac_mul_seq #(.CHECK_FAC(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fa(fa), .fb(fb), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_err(out_err)
  );

  gf16_fac_mul_seq #(.CHECK_FAC(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nc),
    .fa(fa), .fb(fb), .out_valid(out_valid_nc), .out_ready(out_ready),
    .out_p(out_p_nc), .out_err(out_err_nc)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [8:0] fac(input logic [3:0] x);
    logic [1:0] h, l, s;
    h = x[3:2];
    l = x[1:0];
    s = h ^ l;
    return {^s, s, ^h, h, ^l, l};
  endfunction

  // GF(4) normal basis (W^2, W): 01=W, 10=W^2, 11=1; multiply via logs.
  function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] y);
    int lg [4];
    logic [1:0] ex [3];
    lg = '{0, 1, 2, 0};
    ex = '{2'b11, 2'b01, 2'b10};
    if (x == 2'b00 || y == 2'b00) return 2'b00;
    return ex[(lg[x] + lg[y]) % 3];
  endfunction

  // Tower product with N = W^2.
  function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] t;
    t = gf4_mul(gf4_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]), 2'b10);
    return {gf4_mul(a[3:2], b[3:2]) ^ t, gf4_mul(a[1:0], b[1:0]) ^ t};
  endfunction

  task automatic do_op(input logic [8:0] a, input logic [8:0] b,
                       output logic [3:0] p, output logic e, output logic enc,
                       output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 16) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b1;
    fa = a;
    fb = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    fa = 9'($urandom);
    fb = 9'($urandom);
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1; lat++;
    end
    p   = out_p;
    e   = out_err;
    enc = out_err_nc;
  endtask

  task automatic finish_xfer(input bit rnd, input logic [3:0] hp);
    int n;
    n = 0;
    while (out_valid && n < 32) begin
      out_ready = (rnd && n < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1; n++;
      if (rnd && out_valid) begin
        checks++;
        if (out_p !== hp) begin
          errors++;
          $display("FAIL stall_hold: out_p=%h required %h", out_p, hp);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL xfer_done: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== 4'h0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b p=%h err=%b required 1 0 0 0",
               in_ready, out_valid, out_p, out_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed(input string name, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] want);
    logic [3:0] p;
    logic e, enc;
    int lat;
    out_ready = 1'b1;
    do_op(fac(a), fac(b), p, e, enc, lat);
    checks++;
    if (p !== want || e !== 1'b0 || lat != 3) begin
      errors++;
      $display("FAIL %s: p=%h err=%b lat=%0d required p=%h err=0 lat=3", name, p, e, lat, want);
    end
    finish_xfer(1'b0, p);
  endtask

  task automatic test_backpressure;
    logic [3:0] p;
    logic e, enc;
    int lat;
    out_ready = 1'b0;
    do_op(fac(4'h6), fac(4'h6), p, e, enc, lat);
    checks++;
    if (p !== 4'h3 || lat != 3) begin
      errors++;
      $display("FAIL bp_product: p=%h lat=%0d required 3 3", p, lat);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      fa = fac(4'(i + 1));
      fb = fac(4'hF);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_p !== 4'h3 || out_err !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b p=%h err=%b required 1 0 3 0",
                 i, out_valid, in_ready, out_p, out_err);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_ghost: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_corrupt;
    logic [3:0] p;
    logic e, enc;
    int lat;
    out_ready = 1'b1;
    do_op(fac(4'h6) ^ 9'h020, fac(4'hF), p, e, enc, lat);
    checks++;
    if (e !== 1'b1 || enc !== 1'b0) begin
      errors++;
      $display("FAIL corrupt_err: err=%b err_nocheck=%b required 1 0", e, enc);
    end
    finish_xfer(1'b0, p);
  endtask

  task automatic test_reset_mid;
    logic [3:0] p;
    logic e, enc;
    int lat;
    in_valid = 1'b1;
    fa = fac(4'h3);
    fb = fac(4'h5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== 4'h0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b vld=%b p=%h err=%b required 1 0 0 0",
               in_ready, out_valid, out_p, out_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_drop: vld=%b required 0", out_valid);
    end
    do_op(fac(4'hF), fac(4'h9), p, e, enc, lat);
    checks++;
    if (p !== 4'h9 || lat != 3 || e !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_op: p=%h lat=%0d err=%b required 9 3 0", p, lat, e);
    end
    finish_xfer(1'b0, p);
  endtask

  task automatic test_exhaustive;
    logic [3:0] p, want;
    logic e, enc;
    int lat;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        want = ref_mul(4'(a), 4'(b));
        out_ready = 1'($urandom_range(0, 1));
        do_op(fac(4'(a)), fac(4'(b)), p, e, enc, lat);
        checks++;
        if (p !== want || e !== 1'b0 || enc !== 1'b0 || lat != 3) begin
          errors++;
          $display("FAIL exh %h*%h: p=%h err=%b/%b lat=%0d required p=%h err=0/0 lat=3",
                   a[3:0], b[3:0], p, e, enc, lat, want);
        end
        finish_xfer(1'b1, p);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    fa = '0;
    fb = '0;
    test_reset;
    test_directed("identity", 4'h6, 4'hF, 4'h6);
    test_directed("square",   4'h6, 4'h6, 4'h3);
    test_directed("zero",     4'h0, 4'hB, 4'h0);
    test_backpressure;
    test_corrupt;
    test_reset_mid;
    test_exhaustive;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
